// File: rtl/sa_cell_mac.sv
// ---------------------------------------------------------------------------
// sa_cell_mac: processing element for the spatial array.
//
// Signed-integer MAC cell with a loadable weight buffer, command-driven
// modes (weight load, multiply-accumulate, element-wise add/sub, partial-sum
// drain), a saturating accumulator and a valid/ready partials FIFO.
// Activations flow left->right, partial sums top->bottom, and captured row
// results leave through data_out.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_mode                        0 LOAD, 1 MAC, 2 EWISE, 3 DRAIN
//   cmd_len                         weight count for LOAD
//   data_in/data_in_valid           weight write port (LOAD)
//   left_in/left_valid/left_last    activation stream (RUN)
//   right_out/right_valid           activation forwarded with 1-cycle latency
//   result_in                       partial sum from the cell above
//   result_out/result_valid         saturated partial sum to the cell below
//   wd_buffer_pop_index             weight select for MAC
//   add_sub                         0 add, 1 subtract
//   data_out/data_out_valid/ready   partials FIFO drain (DRAIN)
//   wd_count                        number of valid weights
//   sat_flag/ovf_flag/idx_err       sticky status, cleared on command accept
// ---------------------------------------------------------------------------
module sa_cell_mac #(
    parameter int DATA_WIDTH      = 16,
    parameter int ACC_WIDTH       = 40,
    parameter int WD_BUFFER_DEPTH = 16,
    parameter int PARTIALS_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_mode,
    input  logic [$clog2(WD_BUFFER_DEPTH):0]   cmd_len,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               data_in_valid,
    input  logic [DATA_WIDTH-1:0]              left_in,
    input  logic                               left_valid,
    input  logic                               left_last,
    output logic [DATA_WIDTH-1:0]              right_out,
    output logic                               right_valid,
    input  logic [ACC_WIDTH-1:0]               result_in,
    output logic [ACC_WIDTH-1:0]               result_out,
    output logic                               result_valid,
    input  logic [$clog2(WD_BUFFER_DEPTH)-1:0] wd_buffer_pop_index,
    input  logic                               add_sub,
    output logic [ACC_WIDTH-1:0]               data_out,
    output logic                               data_out_valid,
    input  logic                               data_out_ready,
    output logic [$clog2(WD_BUFFER_DEPTH):0]   wd_count,
    output logic                               sat_flag,
    output logic                               ovf_flag,
    output logic                               idx_err
);

    localparam int WI = $clog2(WD_BUFFER_DEPTH);
    localparam int PI = $clog2(PARTIALS_DEPTH);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [WI:0]        WD_ONE   = (WI+1)'(1);
    localparam logic [WI:0]        WD_DEPTH = (WI+1)'(WD_BUFFER_DEPTH);
    localparam logic [PI:0]        PF_DEPTH = (PI+1)'(PARTIALS_DEPTH);
    localparam logic [PI:0]        PF_ONE   = (PI+1)'(1);
    localparam logic [PI-1:0]      PP_ONE   = PI'(1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {M_LOAD, M_MAC, M_EWISE, M_DRAIN} mode_t;

    state_t state;
    mode_t  mode;
    logic [WI:0] target;

    logic [DATA_WIDTH-1:0] wbuf [WD_BUFFER_DEPTH];
    logic [ACC_WIDTH-1:0]  fifo_mem [PARTIALS_DEPTH];
    logic [PI-1:0]         wr_ptr, rd_ptr;
    logic [PI:0]           fifo_count;

    // ------------------------------------------------------------------
    // Datapath: weight select, product/element term, widened add/sub and
    // saturation back to ACC_WIDTH.
    // ------------------------------------------------------------------
    logic                       idx_bad;
    logic signed [PW-1:0]       act_ext, wgt_ext, prod;
    logic signed [ACC_WIDTH:0]  term, rin_ext, sum;
    logic [ACC_WIDTH-1:0]       sat_val;
    logic                       sat_hit;

    always_comb begin
        // NOTE: every variable in a combinational block gets a default first so no latch is inferred.
        idx_bad = ({1'b0, wd_buffer_pop_index} >= wd_count);
        act_ext = {{DATA_WIDTH{left_in[DATA_WIDTH-1]}}, left_in};
        wgt_ext = '0;
        if (!idx_bad) begin
            wgt_ext = {{DATA_WIDTH{wbuf[wd_buffer_pop_index][DATA_WIDTH-1]}},
                       wbuf[wd_buffer_pop_index]};
        end
        // The full product always fits PW signed bits, so the low half is exact.
        prod = act_ext * wgt_ext;
        if (mode == M_MAC) begin
            term = {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};
        end else begin
            term = {{(ACC_WIDTH+1-DATA_WIDTH){left_in[DATA_WIDTH-1]}}, left_in};
        end
        rin_ext = {result_in[ACC_WIDTH-1], result_in};
        sum     = add_sub ? (rin_ext - term) : (rin_ext + term);
        // Top two bits disagree: the true value left the ACC_WIDTH range.
        sat_hit = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
        if (sat_hit) begin
            sat_val = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_val = sum[ACC_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Handshake and strobe decode
    // ------------------------------------------------------------------
    logic cmd_fire, load_beat, load_done, run_beat, fifo_full, fifo_push, fifo_pop;

    always_comb begin
        cmd_ready      = (state == S_IDLE);
        cmd_fire       = cmd_valid && cmd_ready;
        load_beat      = (state == S_LOAD) && data_in_valid && (target != '0);
        load_done      = load_beat && ((wd_count + WD_ONE) == target);
        run_beat       = (state == S_RUN) && left_valid;
        fifo_full      = (fifo_count == PF_DEPTH);
        fifo_push      = run_beat && left_last && !fifo_full;
        data_out_valid = (state == S_DRAIN) && (fifo_count != '0);
        // Gated so data_out reads 0 outside a valid drain beat, including reset.
        data_out       = data_out_valid ? fifo_mem[rd_ptr] : '0;
        fifo_pop       = data_out_valid && data_out_ready;
    end

    // ------------------------------------------------------------------
    // Storage arrays
    // ------------------------------------------------------------------
    // NOTE: the weight buffer and FIFO storage carry no reset; wd_count and the FIFO pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (load_beat) begin
            wbuf[wd_count[WI-1:0]] <= data_in;
        end
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= sat_val;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, flags, forwarding and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            mode         <= M_LOAD;
            target       <= '0;
            wd_count     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            sat_flag     <= 1'b0;
            ovf_flag     <= 1'b0;
            idx_err      <= 1'b0;
            right_out    <= '0;
            right_valid  <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
        end else begin
            right_out    <= left_in;
            right_valid  <= left_valid;
            result_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        mode     <= mode_t'(cmd_mode);
                        sat_flag <= 1'b0;
                        ovf_flag <= 1'b0;
                        idx_err  <= 1'b0;
                        case (mode_t'(cmd_mode))
                            M_LOAD: begin
                                state    <= S_LOAD;
                                wd_count <= '0;
                                target   <= (cmd_len > WD_DEPTH) ? WD_DEPTH : cmd_len;
                            end
                            M_DRAIN: state <= S_DRAIN;
                            default: state <= S_RUN;
                        endcase
                    end
                end

                S_LOAD: begin
                    if (target == '0) begin
                        state <= S_IDLE;
                    end else if (load_beat) begin
                        wd_count <= wd_count + WD_ONE;
                        if (load_done) state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    if (run_beat) begin
                        result_out   <= sat_val;
                        result_valid <= 1'b1;
                        if (sat_hit) sat_flag <= 1'b1;
                        if (mode == M_MAC && idx_bad) idx_err <= 1'b1;
                        if (left_last) begin
                            state <= S_IDLE;
                            if (fifo_full) begin
                                ovf_flag <= 1'b1;
                            end else begin
                                wr_ptr     <= wr_ptr + PP_ONE;
                                fifo_count <= fifo_count + PF_ONE;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    // Leave one cycle after the FIFO is observed empty.
                    if (fifo_count == '0) begin
                        state <= S_IDLE;
                    end else if (fifo_pop) begin
                        rd_ptr     <= rd_ptr + PP_ONE;
                        fifo_count <= fifo_count - PF_ONE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_cell_mac.sv
// ---------------------------------------------------------------------------
// tb_sa_cell_mac: directed bench for sa_cell_mac (DATA_WIDTH=16,
// ACC_WIDTH=32, WD_BUFFER_DEPTH=16, PARTIALS_DEPTH=4). Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sa_cell_mac;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int WD = 16;
    localparam int PD = 4;
    localparam int WI = $clog2(WD);

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_mode;
    logic [WI:0]   cmd_len;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic [DW-1:0] left_in;
    logic          left_valid, left_last;
    logic [DW-1:0] right_out;
    logic          right_valid;
    logic [AW-1:0] result_in, result_out;
    logic          result_valid;
    logic [WI-1:0] wd_buffer_pop_index;
    logic          add_sub;
    logic [AW-1:0] data_out;
    logic          data_out_valid, data_out_ready;
    logic [WI:0]   wd_count;
    logic          sat_flag, ovf_flag, idx_err;

    int n_assert = 0;
    int n_fail   = 0;

    sa_cell_mac #(
        .DATA_WIDTH(DW), .ACC_WIDTH(AW),
        .WD_BUFFER_DEPTH(WD), .PARTIALS_DEPTH(PD)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .left_in(left_in), .left_valid(left_valid), .left_last(left_last),
        .right_out(right_out), .right_valid(right_valid),
        .result_in(result_in), .result_out(result_out), .result_valid(result_valid),
        .wd_buffer_pop_index(wd_buffer_pop_index), .add_sub(add_sub),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .wd_count(wd_count), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
        .idx_err(idx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] m, input logic [WI:0] l);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_mode = 0; cmd_len = 0;
        data_in = 0; data_in_valid = 0;
        left_in = 0; left_valid = 0; left_last = 0;
        result_in = 0; wd_buffer_pop_index = 0; add_sub = 0;
        data_out_ready = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #3;
        // ---------------- reset state ----------------
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wd_count", wd_count, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_data_out_valid", data_out_valid, 0);
        check("rst_flags", {sat_flag, ovf_flag, idx_err}, 0);
        tick();
        rst = 1'b0;
        tick();

        // ---------------- LOAD 3 weights: 2, -3, 5 ----------------
        cmd(2'd0, 5'd3);
        check("load_busy", cmd_ready, 0);
        check("load_entry_count", wd_count, 0);
        data_in_valid = 1; data_in = 16'd2;
        tick();
        check("load_beat1", wd_count, 1);
        data_in = 16'hFFFD;
        left_in = 16'hFFF9; left_valid = 1;
        tick();
        check("fwd_in_load", right_out, 16'hFFF9);
        check("fwd_valid_in_load", right_valid, 1);
        left_valid = 0;
        data_in = 16'd5;
        tick();
        check("load_beat3", wd_count, 3);
        check("load_done_ready", cmd_ready, 1);
        data_in_valid = 0;

        // ---------------- MAC with weights 2,-3,5 ----------------
        cmd(2'd1, 5'd0);
        left_valid = 1; left_in = 16'd4; result_in = 32'd10;
        wd_buffer_pop_index = 4'd1; add_sub = 0;
        tick();
        check("mac_add", result_out, 32'hFFFF_FFFE);
        check("mac_add_valid", result_valid, 1);
        check("fwd_in_run", right_out, 16'd4);
        add_sub = 1;
        tick();
        check("mac_sub", result_out, 32'd22);
        wd_buffer_pop_index = 4'd7; add_sub = 0; left_last = 1;
        tick();
        check("mac_idx_oob", result_out, 32'd10);
        check("idx_err_set", idx_err, 1);
        check("run_end_idle", cmd_ready, 1);
        left_last = 0; left_in = 16'hFFF9;
        tick();
        check("fwd_in_idle", right_out, 16'hFFF9);
        check("idle_no_result", result_valid, 0);
        check("result_held", result_out, 32'd10);
        left_valid = 0;

        // ---------------- EWISE subtract ----------------
        cmd(2'd2, 5'd0);
        check("idx_err_cleared", idx_err, 0);
        left_valid = 1; left_last = 1; left_in = 16'hFFF9;
        result_in = 32'd100; add_sub = 1;
        tick();
        check("ewise_sub", result_out, 32'd107);
        check("ewise_fwd", right_out, 16'hFFF9);
        left_valid = 0; left_last = 0;

        // ---------------- LOAD 20 clamps at 16 ----------------
        cmd(2'd0, 5'd20);
        data_in_valid = 1;
        for (int i = 0; i < WD; i++) begin
            data_in = (i == 0) ? 16'd32767 : (i == 1) ? 16'd1 : DW'(i);
            tick();
            if (i == WD - 2) check("load20_not_done", cmd_ready, 0);
        end
        check("load20_count", wd_count, 16);
        check("load20_idle", cmd_ready, 1);
        tick();
        check("load20_idle_ignores", wd_count, 16);
        data_in_valid = 0;

        // ---------------- saturation ----------------
        cmd(2'd1, 5'd0);
        left_valid = 1; left_in = 16'd32767; wd_buffer_pop_index = 4'd0;
        result_in = 32'h7FFF_FFFF; add_sub = 0;
        tick();
        check("sat_pos", result_out, 32'h7FFF_FFFF);
        check("sat_flag_set", sat_flag, 1);
        result_in = 32'h8000_0000; add_sub = 1; left_last = 1;
        tick();
        check("sat_neg", result_out, 32'h8000_0000);
        left_valid = 0; left_last = 0; add_sub = 0;

        // ---------------- flush FIFO: 10, 107, 0x80000000 ----------------
        cmd(2'd3, 5'd0);
        check("sat_flag_cleared", sat_flag, 0);
        data_out_ready = 1;
        check("flush0", data_out, 32'd10);
        check("flush0_valid", data_out_valid, 1);
        left_valid = 1; left_in = 16'hFFF9;
        tick();
        check("fwd_in_drain", right_out, 16'hFFF9);
        left_valid = 0;
        check("flush1", data_out, 32'd107);
        tick();
        check("flush2", data_out, 32'h8000_0000);
        tick();
        check("flush_empty", data_out_valid, 0);
        check("flush_still_drain", cmd_ready, 0);
        tick();
        check("flush_idle", cmd_ready, 1);
        data_out_ready = 0;

        // ---------------- five runs, results 1..5, overflow ----------------
        for (int k = 1; k <= 5; k++) begin
            cmd(2'd1, 5'd0);
            left_valid = 1; left_last = 1; left_in = DW'(k);
            wd_buffer_pop_index = 4'd1; result_in = 0; add_sub = 0;
            tick();
            check("run_result", result_out, 64'(k));
            if (k == 4) check("ovf_not_yet", ovf_flag, 0);
            left_valid = 0; left_last = 0;
        end
        check("ovf_set", ovf_flag, 1);

        // ---------------- DRAIN with ready toggling ----------------
        cmd(2'd3, 5'd0);
        for (int v = 1; v <= 4; v++) begin
            data_out_ready = 0;
            check("drain_head", data_out, 64'(v));
            check("drain_valid", data_out_valid, 1);
            tick();
            check("drain_stall_hold", data_out, 64'(v));
            data_out_ready = 1;
            tick();
        end
        check("drain_empty", data_out_valid, 0);
        check("drain_still", cmd_ready, 0);
        tick();
        check("drain_idle", cmd_ready, 1);
        data_out_ready = 0;

        // ---------------- reset two beats into LOAD ----------------
        cmd(2'd0, 5'd5);
        data_in_valid = 1; data_in = 16'd9; left_valid = 1; left_in = 16'd3;
        tick();
        tick();
        check("pre_rst_count", wd_count, 2);
        rst = 1'b1;
        #1;
        check("async_rst_right", {right_out, right_valid}, 0);
        check("async_rst_result", {result_out, result_valid}, 0);
        check("async_rst_data_out", {data_out, data_out_valid}, 0);
        check("async_rst_count", wd_count, 0);
        check("async_rst_flags", {sat_flag, ovf_flag, idx_err}, 0);
        check("async_rst_ready", cmd_ready, 1);
        idle_inputs();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_count", wd_count, 0);

        // LOAD with cmd_len = 0 returns the next cycle
        cmd(2'd0, 5'd0);
        check("len0_busy", cmd_ready, 0);
        tick();
        check("len0_idle", cmd_ready, 1);
        check("len0_count", wd_count, 0);

        // DRAIN on an empty FIFO
        cmd(2'd3, 5'd0);
        check("empty_drain_valid", data_out_valid, 0);
        check("empty_drain_busy", cmd_ready, 0);
        tick();
        check("empty_drain_idle", cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
